back_propper: RTL and testbench
===============================

# back_propper

Single trainable neuron for the neuron-array datapath: 32 signed dendrite inputs, 32 synaptic weights plus one bias weight, a registered axon output, and an on-chip gradient step driven by an external error term. The block computes the forward dot product, propagates error to the previous layer, and updates its own weights with a rational learning rate `training_mul / training_div`. It is the leaf compute element instantiated per neuron by the layer wrappers.

## Interface
- No parameters; `N_DENDRITES = 32` and `WIDTH = 32` are package constants.
- `clock`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `dendrites`  in  [31:0][31:0]  signed input activations
- `backprop`  in  32  signed error term for this neuron
- `training_mul`  in  32  unsigned learning-rate numerator
- `training_div`  in  32  unsigned learning-rate denominator
- `train_en`  in  1  apply a weight update at this edge
- `backprop_change`  out  [31:0][31:0]  signed error propagated to each dendrite source
- `axon`  out  32  signed neuron output

## Operation
- Weight store: `w[0..31]` (synaptic) and `w[32]` (bias), 32-bit signed registers.
- Forward: `sum = Σ dendrites[i]*w[i] + w[32]`. Each product is a 64-bit signed value. Accumulate at 70 bits. `axon` takes the low 32 bits (two's-complement wrap).
- Error out: `backprop_change[i] = low32(backprop * w[i])`, computed from current (pre-update) weights.
- Update when `train_en=1` and `training_div != 0`:
  - `delta_i = trunc0((backprop*dendrites[i]) * training_mul / training_div)`. Numerator is 96-bit signed. Division truncates toward zero.
  - `w[i] += low32(delta_i)`, with wrap.
  - The bias uses dendrite value 1: `delta_32 = trunc0(backprop*training_mul/training_div)`.
- `training_div == 0`: no weight change, regardless of `train_en`.
- All arithmetic is signed; mul/div operands are zero-extended.

## Timing
- Reset value:
  - All weights, `axon` and `backprop_change` are 0, asynchronously on `reset_n` low.
  - Outputs hold 0 while reset is held.
- `axon` and `backprop_change` are registered, with 1-cycle latency from `dendrites`/`backprop`. The values use the weights in effect before that edge.
- A weight update at edge k is visible in `axon` and `backprop_change` registered at edge k+1.
- When training and forward evaluation coincide at the same edge, both use the pre-update weights. There are no read-after-write hazards.
- `train_en` held high updates at every edge. There is no handshake or busy state, and throughput is one sample per cycle.
- Reset asserted mid-training discards the pending update.

## Configuration
- `NEURON_RELU_EN` defined:
  - `axon = max(0, low32(sum))`, evaluated as signed.
  - If the current-cycle signed `low32(sum) < 0`, then `backprop_change` is registered as 0 and the weight update is suppressed. This is the ReLU derivative gate.
  - `sum == 0` passes.
- `NEURON_RELU_EN` undefined: linear activation, no gating.

## Structure
- Package `neuron_pkg`:
  - `N_DENDRITES`, `WIDTH`.
  - Typedefs `word_t` (signed 32) and `dendrite_vec_t` ([31:0] of `word_t`).
  - Accumulator width constant (70).
- Sub-module `neuron_dot`: a combinational 32-way multiply-accumulate plus bias, producing the 70-bit `sum`. It is used by `back_propper` for the forward path and the ReLU gate.

## Test plan
- Reset with random inputs -> `axon = 0` and all `backprop_change = 0`. After release with `train_en=0`, outputs stay 0 because weights are 0.
- `dendrites[0]=2`, others 0, `backprop=3`, `mul=1`, `div=1`, `train_en` for one cycle -> `w[0]=6`, `w[32]=3`. The next registered `axon` is 15 and `backprop_change[0]` is 18.
- Same stimulus with `training_div=0` for 5 cycles -> weights stay 0 and `axon` stays 0.
- Rounding toward zero: `dendrites[0]=1`, `backprop=-3`, `mul=1`, `div=2` -> `w[0]=-1`, `w[32]=-1`. Then `dendrites[0]=1` gives `axon=-2` (linear build).
- Wrap: preload `w[0]=0x7FFFFFFF` via training, apply `delta=+1` -> `w[0]=0x80000000`, and `axon` wraps negative.
- `NEURON_RELU_EN` defined with negative `sum` (weights from the rounding scenario) -> `axon=0`, `backprop_change` is all 0, and `train_en` leaves the weights unchanged.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared types and widths for the trainable-neuron datapath.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package neuron_pkg;

  localparam int N_DENDRITES = 32;
  localparam int WIDTH       = 32;
  localparam int PROD_W      = 2 * WIDTH;  // full signed product of two words
  localparam int ACC_W       = 70;         // 32 products plus bias never overflow this
  localparam int NUM_W       = 96;         // gradient numerator: 64-bit product times 33-bit rate

  typedef logic signed [WIDTH-1:0] word_t;
  typedef word_t [N_DENDRITES-1:0] dendrite_vec_t;

  // Full-precision signed word product.
  function automatic logic signed [PROD_W-1:0] mul_ss(input word_t a, input word_t b);
    return PROD_W'(a) * PROD_W'(b);
  endfunction

endpackage

// File: rtl/back_propper_if.sv
// Bundle of the neuron's data, training and result signals.
// Latency: n/a (wiring only).
// Backpressure: none; every signal is sampled or presented every cycle.
interface back_propper_if;
  import neuron_pkg::*;

  dendrite_vec_t dendrites;
  word_t         backprop;
  logic [31:0]   training_mul;
  logic [31:0]   training_div;
  logic          train_en;
  dendrite_vec_t backprop_change;
  word_t         axon;

  modport master (
    output dendrites, backprop, training_mul, training_div, train_en,
    input  backprop_change, axon
  );

  modport slave (
    input  dendrites, backprop, training_mul, training_div, train_en,
    output backprop_change, axon
  );

endinterface

// File: rtl/neuron_dot.sv
// Combinational 32-way signed multiply-accumulate plus bias.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module neuron_dot
  import neuron_pkg::*;
(
  input  dendrite_vec_t            dendrites,
  input  dendrite_vec_t            weights,
  input  word_t                    bias,
  output logic signed [ACC_W-1:0]  sum
);

  word_t                     d_i;
  word_t                     w_i;
  logic signed [PROD_W-1:0]  prod;

  // Accumulate every dendrite/weight product on top of the sign-extended bias.
  always_comb begin
    d_i  = '0;
    w_i  = '0;
    prod = '0;
    sum  = ACC_W'(bias);
    for (int i = 0; i < N_DENDRITES; i++) begin
      d_i  = dendrites[i];
      w_i  = weights[i];
      prod = mul_ss(d_i, w_i);
      sum  = sum + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/back_propper.sv
// Single trainable neuron: forward dot product, error propagation, in-place gradient step.
// Latency: axon/backprop_change registered 1 cycle after inputs; weight update visible one edge later.
// Backpressure: none; accepts one sample per cycle. Define NEURON_RELU_EN for ReLU activation and gating.
module back_propper
  import neuron_pkg::*;
(
  input  logic            clock,
  input  logic            reset_n,
  back_propper_if.slave   bus
);

  dendrite_vec_t             w_q;
  word_t                     bias_q;
  word_t                     axon_q;
  dendrite_vec_t             bpc_q;

  logic signed [ACC_W-1:0]   sum;
  logic                      unused_sum_hi;
  logic                      gate;
  word_t                     axon_nxt;
  dendrite_vec_t             bpc_nxt;
  dendrite_vec_t             w_nxt;
  word_t                     bias_nxt;
  logic                      do_update;

  logic signed [NUM_W-1:0]   mul_ext;
  logic signed [NUM_W-1:0]   div_ext;
  logic signed [NUM_W-1:0]   num;
  logic signed [NUM_W-1:0]   num_b;
  word_t                     d_i;
  word_t                     w_i;

  neuron_dot u_dot (
    .dendrites (bus.dendrites),
    .weights   (w_q),
    .bias      (bias_q),
    .sum       (sum)
  );

  // Only the low word of the accumulator reaches the output; the upper bits exist for exactness.
  assign unused_sum_hi = ^sum[ACC_W-1:WIDTH];

  // The learning rate is unsigned; zero-extend so the signed divide treats it as positive.
  assign mul_ext = $signed({64'd0, bus.training_mul});
  assign div_ext = $signed({64'd0, bus.training_div});

  // Activation and derivative gate, evaluated on this cycle's pre-update weights.
  always_comb begin
    gate     = 1'b0;
    axon_nxt = sum[WIDTH-1:0];
`ifdef NEURON_RELU_EN
    gate     = sum[WIDTH-1];
    if (gate) begin
      axon_nxt = '0;
    end
`endif
  end

  // Error back to each source and the next weight set, both from pre-update weights.
  always_comb begin
    bpc_nxt  = '0;
    w_nxt    = w_q;
    d_i      = '0;
    w_i      = '0;
    num      = '0;
    for (int i = 0; i < N_DENDRITES; i++) begin
      d_i        = bus.dendrites[i];
      w_i        = w_q[i];
      bpc_nxt[i] = gate ? '0 : WIDTH'(mul_ss(bus.backprop, w_i));
      num        = NUM_W'(mul_ss(bus.backprop, d_i)) * mul_ext;
      w_nxt[i]   = w_i + WIDTH'(num / div_ext);
    end
    // The bias behaves as a weight on a constant input of 1.
    num_b    = NUM_W'(bus.backprop) * mul_ext;
    bias_nxt = bias_q + WIDTH'(num_b / div_ext);
  end

  // A zero divisor would make the quotient meaningless, so it also blocks the update.
  assign do_update = bus.train_en && (bus.training_div != '0) && !gate;

  // Register outputs every cycle; commit the weight step only when enabled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      w_q    <= '0;
      bias_q <= '0;
      axon_q <= '0;
      bpc_q  <= '0;
    end else begin
      axon_q <= axon_nxt;
      bpc_q  <= bpc_nxt;
      if (do_update) begin
        w_q    <= w_nxt;
        bias_q <= bias_nxt;
      end
    end
  end

  assign bus.axon            = axon_q;
  assign bus.backprop_change = bpc_q;

endmodule

// File: tb/tb_back_propper.sv
module tb_back_propper;
  import neuron_pkg::*;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  back_propper_if bus();

  back_propper dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0]       axon;
    logic [31:0][31:0] bpc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   mw[33];        // reference weights; index 32 is the bias

  // Truncate-toward-zero of p*m/dz, done on magnitudes, returned modulo 2^32.
  function automatic int trunc_div(input longint p, input int unsigned m, input int unsigned dz);
    logic [127:0] mag;
    logic [127:0] q;
    bit           neg;
    int           r;
    neg = (p < 0);
    mag = neg ? 128'(-p) : 128'(p);
    q   = (mag * 128'(m)) / 128'(dz);
    r   = int'(q[31:0]);
    return neg ? -r : r;
  endfunction

  function automatic int rnd_word();
    if ($urandom_range(0, 3) == 0) return int'($urandom());
    return int'($urandom_range(0, 16)) - 8;
  endfunction

  // Apply one sample at a negedge, predict the registered result, advance the model.
  task automatic drive(input int dv[32], input int bp, input int unsigned m,
                       input int unsigned dz, input bit te);
    logic signed [127:0] s;
    int   low;
    bit   gate;
    exp_t e;
    for (int i = 0; i < 32; i++) bus.dendrites[i] = dv[i];
    bus.backprop     = bp;
    bus.training_mul = m;
    bus.training_div = dz;
    bus.train_en     = te;

    s = 0;
    for (int i = 0; i < 32; i++) s = s + (longint'(dv[i]) * longint'(mw[i]));
    s = s + mw[32];
    low = s[31:0];
`ifdef NEURON_RELU_EN
    gate = (low < 0);
`else
    gate = 1'b0;
`endif
    e.axon = gate ? 0 : low;
    for (int i = 0; i < 32; i++)
      e.bpc[i] = gate ? 0 : int'(longint'(bp) * longint'(mw[i]));
    exp_q.push_back(e);

    if (te && dz != 0 && !gate) begin
      for (int i = 0; i < 33; i++)
        mw[i] = mw[i] + trunc_div(longint'(bp) * longint'((i < 32) ? dv[i] : 1), m, dz);
    end
    @(negedge clock);
  endtask

  // Assert reset with live random inputs and training enabled; outputs must read zero.
  task automatic do_reset();
    reset_n = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 33; i++) mw[i] = 0;
    for (int i = 0; i < 32; i++) bus.dendrites[i] = rnd_word();
    bus.backprop     = rnd_word();
    bus.training_mul = 1;
    bus.training_div = 1;
    bus.train_en     = 1'b1;
    repeat (2) begin
      @(posedge clock);
      #1;
      checks++;
      if (bus.axon !== '0 || bus.backprop_change !== '0) begin
        errors++;
        $display("FAIL reset_outputs: axon=%h bpc0=%h required 0", bus.axon, bus.backprop_change[0]);
      end
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Scoreboard monitor: one expected result per registered cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.axon !== e.axon) begin
          errors++;
          $display("FAIL axon: got %h want %h", bus.axon, e.axon);
        end
        checks++;
        if (bus.backprop_change !== e.bpc) begin
          errors++;
          for (int i = 0; i < 32; i++)
            if (bus.backprop_change[i] !== e.bpc[i]) begin
              $display("FAIL backprop_change[%0d]: got %h want %h", i, bus.backprop_change[i], e.bpc[i]);
              break;
            end
        end
      end
    end
  end

  initial begin
    int dv[32];
    for (int i = 0; i < 32; i++) bus.dendrites[i] = '0;
    bus.backprop = '0; bus.training_mul = '0; bus.training_div = '0; bus.train_en = 1'b0;
    for (int i = 0; i < 33; i++) mw[i] = 0;
    @(negedge clock);

    // Reset, then idle with random inputs: zero weights keep outputs at zero.
    do_reset();
    repeat (3) begin
      for (int i = 0; i < 32; i++) dv[i] = rnd_word();
      drive(dv, rnd_word(), 1, 1, 1'b0);
    end

    // Single training step: w0=6, bias=3, then axon=15, bpc0=18.
    do_reset();
    dv = '{default: 0}; dv[0] = 2;
    drive(dv, 3, 1, 1, 1'b1);
    drive(dv, 3, 1, 1, 1'b0);
    drive(dv, 3, 1, 1, 1'b0);

    // Zero divisor blocks every update.
    do_reset();
    repeat (5) drive(dv, 3, 1, 0, 1'b1);
    drive(dv, 3, 1, 1, 1'b0);

    // Truncation toward zero: -3/2 -> -1 on w0 and bias; ReLU build gates the follow-up.
    do_reset();
    dv = '{default: 0}; dv[0] = 1;
    drive(dv, -3, 1, 2, 1'b1);
    drive(dv, -3, 1, 2, 1'b1);
    drive(dv, 1, 1, 1, 1'b0);
    drive(dv, 1, 1, 1, 1'b0);

    // Wrap: w0 -> 0x7FFFFFFF, then +1 -> 0x80000000.
    do_reset();
    dv = '{default: 0}; dv[0] = 32'h7FFF_FFFF;
    drive(dv, 1, 1, 1, 1'b1);
    dv[0] = 1;
    drive(dv, 1, 1, 1, 1'b1);
    drive(dv, 1, 1, 1, 1'b0);
    drive(dv, 1, 1, 1, 1'b0);

    // Randomized traffic with occasional mid-training resets.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      int unsigned m, dz;
      if (n % 97 == 50) do_reset();
      for (int i = 0; i < 32; i++) dv[i] = rnd_word();
      m  = ($urandom_range(0, 3) == 0) ? $urandom() : $urandom_range(0, 4);
      dz = ($urandom_range(0, 7) == 0) ? 0 :
           (($urandom_range(0, 3) == 0) ? $urandom() : $urandom_range(1, 4));
      drive(dv, rnd_word(), m, dz, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
